fpmul_seq: RTL and testbench

FPMUL_SEQ -- requirements
Module: fpmul_seq

---
 rtl/dlx_pkg.sv | 13 +
 rtl/mul_iter.sv | 37 +++
 rtl/fpmul_seq.sv | 126 ++++++++++++
 tb/tb_fpmul_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions: multiplier FSM encoding, iteration count and opcode.
package dlx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_WB   = 2'b10
    } fpmul_state_t;

    localparam int          N_CYC    = 32;
    localparam logic [5:0]  OP_FPMUL = 6'b000001;

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier datapath; keeps only the low 32 product bits.
module mul_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [0:31] i_src_a,
    input  logic [0:31] i_src_b,
    output logic [0:31] o_acc
);

    logic [0:31] r_mcand;
    logic [0:31] r_mplier;
    logic [0:31] r_acc;

    // Bit 31 is the LSB of the big-endian-indexed multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_mcand  <= i_src_a;
            r_mplier <= i_src_b;
            r_acc    <= '0;
        end else if (i_step) begin
            if (r_mplier[31]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fpmul_seq.sv
// Sequential FP-register integer multiplier: FSM, iteration counter, hazard
// stall generation and arbitration for the shared FP register-file write port.
module fpmul_seq
    import dlx_pkg::*;
#(
    parameter int N_CYC = dlx_pkg::N_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:31] src_a,
    input  logic [0:31] src_b,
    input  logic [0:4]  dest,
    input  logic        rd_fp_a_v,
    input  logic        rd_fp_b_v,
    input  logic [0:4]  rd_fp_a,
    input  logic [0:4]  rd_fp_b,
    input  logic        pipe_fp_wr,
    input  logic [0:4]  pipe_fp_addr,
    output logic        stall,
    output logic        busy,
    output logic        fp_wr_en,
    output logic [0:4]  fp_wr_addr,
    output logic [0:31] fp_wr_data,
    output logic [1:0]  o_dbg_state
);

    localparam int CNT_W = $clog2(N_CYC);

    fpmul_state_t     r_state;
    fpmul_state_t     w_next;
    logic [CNT_W-1:0] r_count;
    logic [0:4]       r_dest;
    logic [0:4]       r_last_addr;
    logic [0:31]      r_last_data;
    logic [0:31]      w_acc;
    logic             w_load;
    logic             w_step;
    logic             w_wr_en;
    logic             w_active;
    logic             w_raw;
    logic             w_waw;

    assign w_active = (r_state != ST_IDLE);
    assign w_raw    = (rd_fp_a_v && (rd_fp_a == r_dest)) ||
                      (rd_fp_b_v && (rd_fp_b == r_dest));
    assign w_waw    = pipe_fp_wr && (pipe_fp_addr == r_dest);
    assign stall    = w_active && (start || w_raw || w_waw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The pipeline's movi2fp write always wins the shared port; WB waits it out.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_wr_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stall) begin
                    w_load = 1'b1;
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (r_count == CNT_W'(N_CYC - 1)) begin
                    w_next = ST_WB;
                end
            end
            ST_WB: begin
                w_wr_en = ~pipe_fp_wr;
                if (w_wr_en) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_dest      <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            if (w_load) begin
                r_count <= '0;
                r_dest  <= dest;
            end else if (w_step) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_wr_en) begin
                r_last_addr <= r_dest;
                r_last_data <= w_acc;
            end
        end
    end

    mul_iter u_mul_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_src_a (src_a),
        .i_src_b (src_b),
        .o_acc   (w_acc)
    );

    // Outside WB the write port shows the last completed write.
    assign fp_wr_en    = w_wr_en;
    assign fp_wr_addr  = (r_state == ST_WB) ? r_dest : r_last_addr;
    assign fp_wr_data  = (r_state == ST_WB) ? w_acc  : r_last_data;
    assign busy        = w_active;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fpmul_seq.sv
// Self-checking bench for fpmul_seq: vector table, hand-written hazard/reset
// sequences and random operands against a product model.
module tb_fpmul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [0:31] src_a;
    logic [0:31] src_b;
    logic [0:4]  dest;
    logic        rd_fp_a_v;
    logic        rd_fp_b_v;
    logic [0:4]  rd_fp_a;
    logic [0:4]  rd_fp_b;
    logic        pipe_fp_wr;
    logic [0:4]  pipe_fp_addr;
    logic        stall;
    logic        busy;
    logic        fp_wr_en;
    logic [0:4]  fp_wr_addr;
    logic [0:31] fp_wr_data;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[8];

    fpmul_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .src_a        (src_a),
        .src_b        (src_b),
        .dest         (dest),
        .rd_fp_a_v    (rd_fp_a_v),
        .rd_fp_b_v    (rd_fp_b_v),
        .rd_fp_a      (rd_fp_a),
        .rd_fp_b      (rd_fp_b),
        .pipe_fp_wr   (pipe_fp_wr),
        .pipe_fp_addr (pipe_fp_addr),
        .stall        (stall),
        .busy         (busy),
        .fp_wr_en     (fp_wr_en),
        .fp_wr_addr   (fp_wr_addr),
        .fp_wr_data   (fp_wr_data),
        .o_dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every granted write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && fp_wr_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: write addr %0d data 0x%08h, none expected",
                         fp_wr_addr, fp_wr_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({fp_wr_addr, fp_wr_data} !== e) begin
                    n_bad++;
                    $display("FAIL sb_write: got addr %0d data 0x%08h, expected addr %0d data 0x%08h",
                             fp_wr_addr, fp_wr_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // called 1ns after an edge; returns in cycle T (1ns after accept edge)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
        start = 1'b1;
        src_a = a;
        src_b = b;
        dest  = d;
        #1;
        chk("issue_no_stall", {31'b0, stall}, 32'd0);
        exp_q.push_back({d, model(a, b)});
        cyc();
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        chk("busy_from_T", {31'b0, busy}, 32'd1);
    endtask

    task automatic to_wb(input int n);
        int early;
        early = 0;
        for (int k = 0; k < n; k++) begin
            if (fp_wr_en !== 1'b0) early++;
            cyc();
        end
        chk("no_early_write", early, 0);
        chk("state_wb", {30'b0, dbg_state}, 32'd2);
    endtask

    task automatic block_wb(input int n, input logic [31:0] e);
        int bad;
        bad = 0;
        pipe_fp_wr   = 1'b1;
        pipe_fp_addr = 5'($urandom_range(0, 31));
        for (int k = 0; k < n; k++) begin
            #1;
            if (fp_wr_en !== 1'b0 || dbg_state !== 2'd2 || fp_wr_data !== e) bad++;
            cyc();
        end
        pipe_fp_wr = 1'b0;
        chk("wb_blocked", bad, 0);
    endtask

    task automatic finish_wb(input logic [4:0] d, input logic [31:0] e);
        #1;
        chk("wr_en_in_wb", {31'b0, fp_wr_en}, 32'd1);
        chk("wr_addr", {27'b0, fp_wr_addr}, {27'b0, d});
        chk("wr_data", fp_wr_data, e);
        cyc();
        chk("idle_after_wb", {30'b0, dbg_state}, 32'd0);
        chk("busy_low_after_wb", {31'b0, busy}, 32'd0);
        chk("data_held", fp_wr_data, e);
    endtask

    initial begin
        int cnt;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;

        vecs[0] = '{32'h0001_0000, 32'h0001_0000, 5'd1,  32'h0000_0000};
        vecs[1] = '{32'h1234_5678, 32'h0000_0001, 5'd2,  32'h1234_5678};
        vecs[2] = '{32'h0000_0000, 32'h0000_DEAD, 5'd3,  32'h0000_0000};
        vecs[3] = '{32'h8000_0000, 32'h0000_0002, 5'd31, 32'h0000_0000};
        vecs[4] = '{32'h0000_0007, 32'h0000_0006, 5'd0,  32'h0000_002A};
        vecs[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 5'd17, 32'hFFFE_0001};
        vecs[6] = '{32'h0001_0001, 32'h0001_0001, 5'd9,  32'h0002_0001};
        vecs[7] = '{32'h0000_0001, 32'h8000_0000, 5'd30, 32'h8000_0000};

        rst_n = 1'b0; start = 1'b0; src_a = '0; src_b = '0; dest = '0;
        rd_fp_a_v = 1'b0; rd_fp_b_v = 1'b0; rd_fp_a = '0; rd_fp_b = '0;
        pipe_fp_wr = 1'b0; pipe_fp_addr = '0;

        // reset state
        cyc(); cyc();
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_wr_en", {31'b0, fp_wr_en}, 32'd0);
        chk("rst_wr_addr", {27'b0, fp_wr_addr}, 32'd0);
        chk("rst_wr_data", fp_wr_data, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // 3*5 -> dest 4, exact latency
        issue(32'd3, 32'd5, 5'd4);
        to_wb(32);
        finish_wb(5'd4, 32'h0000_000F);

        // overflow discarded
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
        to_wb(32);
        finish_wb(5'd12, 32'h0000_0001);

        // table vectors
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].d);
            to_wb(32);
            finish_wb(vecs[i].d, vecs[i].exp);
        end

        // pipeline write owns the port for 3 WB cycles
        issue(32'd100, 32'd200, 5'd6);
        to_wb(32);
        pipe_fp_wr = 1'b1; pipe_fp_addr = 5'd6;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wb_pipe_prio_en", {31'b0, fp_wr_en}, 32'd0);
            chk("wb_pipe_prio_data", fp_wr_data, 32'd20000);
            cyc();
        end
        pipe_fp_wr = 1'b0;
        finish_wb(5'd6, 32'd20000);

        // hazards while busy with dest 7
        issue(32'd9, 32'd9, 5'd7);
        rd_fp_a_v = 1'b1; rd_fp_a = 5'd7; #1;
        chk("raw_a_hit", {31'b0, stall}, 32'd1);
        cyc();
        rd_fp_a = 5'd6; #1;
        chk("raw_a_miss", {31'b0, stall}, 32'd0);
        cyc();
        rd_fp_a_v = 1'b0; rd_fp_b_v = 1'b1; rd_fp_b = 5'd7; #1;
        chk("raw_b_hit", {31'b0, stall}, 32'd1);
        cyc();
        rd_fp_b_v = 1'b0; pipe_fp_wr = 1'b1; pipe_fp_addr = 5'd7; #1;
        chk("waw_hit", {31'b0, stall}, 32'd1);
        cyc();
        pipe_fp_addr = 5'd3; #1;
        chk("waw_miss", {31'b0, stall}, 32'd0);
        cyc();
        pipe_fp_wr = 1'b0;
        // second start held from cycle T+5 through the WB cycle T+32
        start = 1'b1; src_a = 32'd11; src_b = 32'd13; dest = 5'd2;
        cnt = 0;
        for (int k = 0; k < 28; k++) begin
            #1;
            if (stall !== 1'b1) cnt++;
            if (k == 27) begin
                chk("first_write_under_start", {31'b0, fp_wr_en}, 32'd1);
                chk("first_write_data", fp_wr_data, 32'd81);
            end
            cyc();
        end
        chk("structural_stall", cnt, 0);
        issue(32'd11, 32'd13, 5'd2);
        to_wb(32);
        finish_wb(5'd2, 32'd143);

        // reset mid-operation at count=10
        issue(32'd123, 32'd456, 5'd9);
        for (int k = 0; k < 10; k++) cyc();
        start = 1'b1; rd_fp_a_v = 1'b1; rd_fp_a = 5'd0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_state", {30'b0, dbg_state}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_wr_en", {31'b0, fp_wr_en}, 32'd0);
        chk("mid_rst_wr_addr", {27'b0, fp_wr_addr}, 32'd0);
        chk("mid_rst_wr_data", fp_wr_data, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        start = 1'b0; rd_fp_a_v = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (fp_wr_en !== 1'b0) cnt++;
            cyc();
        end
        chk("abandoned_no_write", cnt, 0);
        issue(32'd2, 32'd2, 5'd5);
        to_wb(32);
        finish_wb(5'd5, 32'h0000_0004);

        // random operands, random pipeline contention in WB
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            d = 5'($urandom_range(0, 31));
            issue(a, b, d);
            to_wb(32);
            block_wb($urandom_range(0, 2), model(a, b));
            finish_wb(d, model(a, b));
            if ($urandom_range(0, 1) == 1) cyc();
        end

        cyc();
        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
